// File: rtl/blink_mode_ctrl.sv
// Mode controller for the LED blink datapath: OFF/ON/per-channel blink FSM,
// output mux select and one saturating rate register per blinker channel.
`timescale 1ns/1ps
module blink_mode_ctrl #(
    parameter  int NUM_CH    = 2,
    parameter  int RATE_W    = 4,
    parameter  int RATE_INIT = 8,
    localparam int SW        = $clog2(2*NUM_CH+2),
    localparam int MW        = $clog2(NUM_CH+2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     next,
    input  logic                     up_button,
    input  logic                     down_button,
    output logic [SW-1:0]            mode_state,
    output logic [MW-1:0]            mux_sel,
    output logic [NUM_CH-1:0]        left,
    output logic [NUM_CH-1:0]        right,
    output logic [NUM_CH*RATE_W-1:0] rate
);

    localparam logic [SW-1:0]     LAST_ST  = SW'(2*NUM_CH+1);
    localparam logic [RATE_W-1:0] RATE_MAX = {RATE_W{1'b1}};
    localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(RATE_INIT);

    logic [SW-1:0]            state_q, state_d;
    logic [NUM_CH*RATE_W-1:0] rate_q, rate_d;
    logic [NUM_CH-1:0]        left_q, left_d, right_q, right_d;
    logic                     next_prev_q, up_prev_q, down_prev_q;
    logic                     next_ev_s, up_ev_s, down_ev_s;
    logic                     blink_s, adj_s;
    logic [SW-1:0]            chan_s;

    assign next_ev_s = next & ~next_prev_q;
    assign up_ev_s   = up_button & ~up_prev_q;
    assign down_ev_s = down_button & ~down_prev_q;

    // Odd states from S3 upward are blink modes; S(2k+1) drives channel k-1.
    assign blink_s = state_q[0] && (state_q != SW'(1));
    assign chan_s  = (state_q >> 1) - SW'(1);
    // A next press, or up and down together, suppresses any rate change.
    assign adj_s   = blink_s && !next_ev_s && (up_ev_s ^ down_ev_s);

    assign mode_state = state_q;
    assign mux_sel    = state_q[0] ? MW'((state_q >> 1) + SW'(1)) : '0;
    assign left       = left_q;
    assign right      = right_q;
    assign rate       = rate_q;

    // State, rate, strobe and button-history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= '0;
            rate_q      <= {NUM_CH{RATE_RST}};
            left_q      <= '0;
            right_q     <= '0;
            next_prev_q <= 1'b1;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            left_q      <= left_d;
            right_q     <= right_d;
            next_prev_q <= next;
            up_prev_q   <= up_button;
            down_prev_q <= down_button;
        end
    end

    // Next-state, saturating rate update and strobe generation.
    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        left_d  = '0;
        right_d = '0;
        if (next_ev_s) begin
            if (state_q == LAST_ST) begin
                state_d = '0;
            end else begin
                state_d = state_q + SW'(1);
            end
        end else begin
            state_d = state_q;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (adj_s && (chan_s == SW'(k))) begin
                if (up_ev_s && (rate_q[k*RATE_W +: RATE_W] != RATE_MAX)) begin
                    rate_d[k*RATE_W +: RATE_W] = rate_q[k*RATE_W +: RATE_W] + RATE_W'(1);
                    left_d[k] = 1'b1;
                end else if (down_ev_s && (rate_q[k*RATE_W +: RATE_W] != '0)) begin
                    rate_d[k*RATE_W +: RATE_W] = rate_q[k*RATE_W +: RATE_W] - RATE_W'(1);
                    right_d[k] = 1'b1;
                end else begin
                    rate_d[k*RATE_W +: RATE_W] = rate_q[k*RATE_W +: RATE_W];
                end
            end else begin
                rate_d[k*RATE_W +: RATE_W] = rate_q[k*RATE_W +: RATE_W];
            end
        end
    end

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Directed, table-driven bench for blink_mode_ctrl: default build (2 channels)
// plus a 3-channel, 3-bit-rate build with RATE_INIT=0.
`timescale 1ns/1ps
module tb_blink_mode_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_next, a_up, a_down;
    logic [2:0] a_state;
    logic [1:0] a_mux, a_left, a_right;
    logic [7:0] a_rate;
    logic       b_next, b_up, b_down;
    logic [2:0] b_state, b_mux, b_left, b_right;
    logic [8:0] b_rate;

    blink_mode_ctrl u_a (
        .clk(clk), .reset(rst_n), .next(a_next), .up_button(a_up), .down_button(a_down),
        .mode_state(a_state), .mux_sel(a_mux), .left(a_left), .right(a_right), .rate(a_rate)
    );

    blink_mode_ctrl #(.NUM_CH(3), .RATE_W(3), .RATE_INIT(0)) u_b (
        .clk(clk), .reset(rst_n), .next(b_next), .up_button(b_up), .down_button(b_down),
        .mode_state(b_state), .mux_sel(b_mux), .left(b_left), .right(b_right), .rate(b_rate)
    );

    typedef struct {
        logic       n, u, d;
        logic [2:0] st;
        logic [1:0] mux, l, r;
        logic [7:0] rt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    int a_st_seq  [6] = '{1, 2, 3, 4, 5, 0};
    int a_mux_seq [6] = '{1, 0, 2, 0, 3, 0};
    int b_st_seq  [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int b_mux_seq [8] = '{1, 0, 2, 0, 3, 0, 4, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic n, input logic u, input logic d, input logic [2:0] st,
                                input logic [1:0] mux, input logic [1:0] l, input logic [1:0] r,
                                input logic [7:0] rt);
        vec_t v;
        v.n = n; v.u = u; v.d = d; v.st = st; v.mux = mux; v.l = l; v.r = r; v.rt = rt;
        vecs.push_back(v);
    endfunction

    task automatic apply_a(input vec_t v, input int idx);
        @(negedge clk);
        a_next = v.n; a_up = v.u; a_down = v.d;
        @(posedge clk);
        #1;
        chk($sformatf("a%0d_state", idx), 32'(a_state), 32'(v.st));
        chk($sformatf("a%0d_mux", idx),   32'(a_mux),   32'(v.mux));
        chk($sformatf("a%0d_left", idx),  32'(a_left),  32'(v.l));
        chk($sformatf("a%0d_right", idx), 32'(a_right), 32'(v.r));
        chk($sformatf("a%0d_rate", idx),  32'(a_rate),  32'(v.rt));
    endtask

    task automatic b_step(input string nm, input logic n, input logic u, input logic d,
                          input logic [2:0] st, input logic [2:0] mux, input logic [2:0] l,
                          input logic [2:0] r, input logic [8:0] rt);
        @(negedge clk);
        b_next = n; b_up = u; b_down = d;
        @(posedge clk);
        #1;
        chk({nm, "_state"}, 32'(b_state), 32'(st));
        chk({nm, "_mux"},   32'(b_mux),   32'(mux));
        chk({nm, "_left"},  32'(b_left),  32'(l));
        chk({nm, "_right"}, 32'(b_right), 32'(r));
        chk({nm, "_rate"},  32'(b_rate),  32'(rt));
    endtask

    initial begin
        int r0;
        int r1;
        int r2;
        logic [1:0] strobe;
        logic [2:0] bstrobe;
        vec_t v;

        // next held across reset release must not advance
        add(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'b00, 2'b00, 8'h88);
        add(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'b00, 2'b00, 8'h88);
        for (int i = 0; i < 6; i++) begin
            add(1'b1, 1'b0, 1'b0, 3'(a_st_seq[i]), 2'(a_mux_seq[i]), 2'b00, 2'b00, 8'h88);
            add(1'b0, 1'b0, 1'b0, 3'(a_st_seq[i]), 2'(a_mux_seq[i]), 2'b00, 2'b00, 8'h88);
        end
        for (int i = 0; i < 3; i++) begin
            add(1'b1, 1'b0, 1'b0, 3'(a_st_seq[i]), 2'(a_mux_seq[i]), 2'b00, 2'b00, 8'h88);
            add(1'b0, 1'b0, 1'b0, 3'(a_st_seq[i]), 2'(a_mux_seq[i]), 2'b00, 2'b00, 8'h88);
        end
        r0 = 8;
        for (int i = 0; i < 10; i++) begin
            strobe = 2'b00;
            if (r0 < 15) begin
                r0 = r0 + 1;
                strobe = 2'b01;
            end
            add(1'b0, 1'b1, 1'b0, 3'd3, 2'd2, strobe, 2'b00, {4'h8, 4'(r0)});
            add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00,  2'b00, {4'h8, 4'(r0)});
        end
        add(1'b0, 1'b0, 1'b1, 3'd3, 2'd2, 2'b00, 2'b01, 8'h8e);
        add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8e);
        add(1'b0, 1'b1, 1'b0, 3'd3, 2'd2, 2'b01, 2'b00, 8'h8f);
        for (int i = 0; i < 19; i++) add(1'b0, 1'b1, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8f);
        add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8f);
        add(1'b0, 1'b1, 1'b1, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8f);
        add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8f);
        add(1'b0, 1'b0, 1'b1, 3'd3, 2'd2, 2'b00, 2'b01, 8'h8e);
        add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h8e);
        add(1'b1, 1'b1, 1'b0, 3'd4, 2'd0, 2'b00, 2'b00, 8'h8e);
        add(1'b0, 1'b0, 1'b0, 3'd4, 2'd0, 2'b00, 2'b00, 8'h8e);
        add(1'b1, 1'b0, 1'b0, 3'd5, 2'd3, 2'b00, 2'b00, 8'h8e);
        add(1'b0, 1'b0, 1'b0, 3'd5, 2'd3, 2'b00, 2'b00, 8'h8e);
        r1 = 8;
        for (int i = 0; i < 9; i++) begin
            strobe = 2'b00;
            if (r1 > 0) begin
                r1 = r1 - 1;
                strobe = 2'b10;
            end
            add(1'b0, 1'b0, 1'b1, 3'd5, 2'd3, 2'b00, strobe, {4'(r1), 4'he});
            add(1'b0, 1'b0, 1'b0, 3'd5, 2'd3, 2'b00, 2'b00,  {4'(r1), 4'he});
        end
        // up/down are ignored outside blink modes
        for (int i = 0; i < 3; i++) begin
            add(1'b1, 1'b0, 1'b0, 3'(i), 2'(a_mux_seq[(i + 5) % 6]), 2'b00, 2'b00, 8'h0e);
            add(1'b0, 1'b1, 1'b0, 3'(i), 2'(a_mux_seq[(i + 5) % 6]), 2'b00, 2'b00, 8'h0e);
            add(1'b0, 1'b0, 1'b0, 3'(i), 2'(a_mux_seq[(i + 5) % 6]), 2'b00, 2'b00, 8'h0e);
            add(1'b0, 1'b0, 1'b1, 3'(i), 2'(a_mux_seq[(i + 5) % 6]), 2'b00, 2'b00, 8'h0e);
            add(1'b0, 1'b0, 1'b0, 3'(i), 2'(a_mux_seq[(i + 5) % 6]), 2'b00, 2'b00, 8'h0e);
        end
        add(1'b1, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h0e);
        add(1'b0, 1'b0, 1'b0, 3'd3, 2'd2, 2'b00, 2'b00, 8'h0e);

        rst_n = 1'b0;
        a_next = 1'b1; a_up = 1'b0; a_down = 1'b0;
        b_next = 1'b0; b_up = 1'b0; b_down = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_mux",   32'(a_mux),   32'd0);
        chk("rst_left",  32'(a_left),  32'd0);
        chk("rst_right", 32'(a_right), 32'd0);
        chk("rst_rate",  32'(a_rate),  32'h88);
        chk("rst_b_rate", 32'(b_rate), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply_a(v, i);
        end

        // reset dropped between edges while a right strobe is high
        @(negedge clk);
        a_down = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_strobe_right", 32'(a_right), 32'h1);
        chk("mid_strobe_rate",  32'(a_rate),  32'h0d);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(a_state), 32'd0);
        chk("async_mux",   32'(a_mux),   32'd0);
        chk("async_right", 32'(a_right), 32'd0);
        chk("async_rate",  32'(a_rate),  32'h88);
        @(negedge clk);
        a_down = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add(1'b1, 1'b0, 1'b0, 3'd1, 2'd1, 2'b00, 2'b00, 8'h88);
        apply_a(vecs[vecs.size() - 1], vecs.size() - 1);

        // 3-channel build: wrap 7->0, mux reaches 4, saturation at 7
        for (int i = 0; i < 8; i++) begin
            b_step("b_seq", 1'b1, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd0);
            b_step("b_rel", 1'b0, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd0);
        end
        for (int i = 0; i < 3; i++) begin
            b_step("b_go3", 1'b1, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd0);
            b_step("b_go3r", 1'b0, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd0);
        end
        b_step("b_dn_sat", 1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 3'b000, 3'b000, 9'd0);
        b_step("b_dn_rel", 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 3'b000, 3'b000, 9'd0);
        b_step("b_up_c0",  1'b0, 1'b1, 1'b0, 3'd3, 3'd2, 3'b001, 3'b000, 9'd1);
        b_step("b_up_rel", 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 3'b000, 3'b000, 9'd1);
        for (int i = 3; i < 7; i++) begin
            b_step("b_go7", 1'b1, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd1);
            b_step("b_go7r", 1'b0, 1'b0, 1'b0, 3'(b_st_seq[i]), 3'(b_mux_seq[i]), 3'b000, 3'b000, 9'd1);
        end
        r2 = 0;
        for (int i = 0; i < 10; i++) begin
            bstrobe = 3'b000;
            if (r2 < 7) begin
                r2 = r2 + 1;
                bstrobe = 3'b100;
            end
            b_step("b_sat", 1'b0, 1'b1, 1'b0, 3'd7, 3'd4, bstrobe, 3'b000, {3'(r2), 3'd0, 3'd1});
            b_step("b_satr", 1'b0, 1'b0, 1'b0, 3'd7, 3'd4, 3'b000, 3'b000, {3'(r2), 3'd0, 3'd1});
        end
        b_step("b_wrap", 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'b000, 3'b000, {3'd7, 3'd0, 3'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_mode_ctrl.md
# blink_mode_ctrl

Parametrised mode controller for the LED blink datapath. It steps through OFF / ON / per-channel blink modes on a `next` press, and drives the output mux select. It also owns one saturating blink-rate register per blinker channel, adjusted by `up_button`/`down_button` only while that channel's mode is active. It contains its own rising-edge detection on all three buttons, so no external one-pulse stages are needed. It sits between the debounced button inputs and the blinker/mux datapath.

## Interface
- `NUM_CH`, default 2: number of blinker channels, legal range 1..6.
- `RATE_W`, default 4: width of each rate register.
- `RATE_INIT`, default 8: reset value of every rate register; must be < 2^RATE_W.
- `SW` (derived, not overridable): clog2(2*NUM_CH+2), the state width.
- `MW` (derived, not overridable): clog2(NUM_CH+2), the mux select width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting (0) clears all state immediately; deassertion is taken synchronously by upstream.
- `next`  in  1  advance mode (level input, debounced, synchronous to clk).
- `up_button`  in  1  increment active channel rate (level input).
- `down_button`  in  1  decrement active channel rate (level input).
- `mode_state`  out  SW  current FSM state.
- `mux_sel`  out  MW  output select: 0 off, 1 steady on, k+2 blinker channel k.
- `left`  out  NUM_CH  one-cycle strobe, bit k: channel k rate incremented.
- `right`  out  NUM_CH  one-cycle strobe, bit k: channel k rate decremented.
- `rate`  out  NUM_CH*RATE_W  packed rate registers; channel k occupies bits [k*RATE_W +: RATE_W].

## Operation
- Edge detect: each button has a prev register. An event is in & ~prev. Prev registers reset to 1, so a button held through reset release does not fire.
- States 0..2*NUM_CH+1:
  - S0 = OFF, S1 = ON.
  - Every even state S2k (k ≥ 1) = OFF gap.
  - S2k+1 (k ≥ 1) = BLINK of channel k-1.
- Next event: state ← state+1. From 2*NUM_CH+1, state wraps to 0. With NUM_CH=2 the sequence is 0,1,2,3,4,5,0.
- mux_sel decode:
  - Even state → 0.
  - S1 → 1.
  - S2k+1 → k+1, i.e. channel k-1 selected.
- Up/down events are acted on only in a BLINK state and only for that state's channel. They are ignored in all other states.
- Up event in BLINK channel c:
  - If rate[c] < 2^RATE_W-1: rate[c] ← rate[c]+1 and left[c] pulses.
  - Otherwise saturated: no change, no pulse.
- Down event in BLINK channel c:
  - If rate[c] > 0: rate[c] ← rate[c]-1 and right[c] pulses.
  - Otherwise saturated: no change, no pulse.
- Simultaneous events:
  - up and down together: both ignored.
  - next together with up or down: next takes effect; the rate is unchanged and no strobe fires.
- Rate registers keep their values across mode changes and wrap-around. Only reset restores RATE_INIT.
- At most one bit of `left|right` is high in any cycle.

## Timing
- Reset (reset=0), asynchronously:
  - mode_state=0, mux_sel=0.
  - left=0, right=0.
  - every rate[k]=RATE_INIT.
  - prev regs=1.
- Latency: a button first seen high in cycle t produces its state, rate and strobe update on the edge ending t, visible in cycle t+1.
- mux_sel is combinational from mode_state, so it changes in the same cycle as mode_state.
- left/right are registered. Each strobe is high for exactly one cycle per qualifying event, even if the button is held for many cycles.
- A held button generates one event. Releasing it for ≥1 cycle and pressing again generates a new event.
- Reset asserted mid-sequence or mid-strobe: outputs clear within the same cycle, without waiting for a clock edge. After reset release the block behaves as from power-up.

## Test plan
- Reset then 6 separate next pulses (NUM_CH=2) → mode_state 1,2,3,4,5,0 and mux_sel 1,0,2,0,3,0, each one cycle after its press.
- In S3, 10 up presses from rate[0]=8 → rate[0] goes 9..15 with 7 left[0] strobes. The last 3 presses give no change and no strobe. rate[1] stays 8.
- In S5, 9 down presses → rate[1] goes 7..0 with 8 right[1] strobes, the 9th press is ignored. Then in S0/S1/S2, up and down presses → no rate change, no strobe.
- up held high 20 cycles in S3 → exactly one left[0] pulse, one cycle wide. up and down rising together → no change. next and up rising together in S3 → state goes to 4, rate[0] unchanged.
- next held high across reset release → no state advance. reset dropped mid-strobe, between clock edges → all outputs return to reset values immediately, rates = RATE_INIT.
- Repeat the sequence and saturation tests with NUM_CH=3, RATE_W=3, RATE_INIT=0 → state wraps from 7 to 0, mux_sel reaches 4, rate saturates at 7.
